// File: rtl/line_window_ctrl_if.sv
// rtl/line_window_ctrl_if.sv - pixel-in / line-buffer / window handshake bundle for line_window_ctrl
//
// Purpose: groups the pixel input stream, the line-buffer shift port and the
// 3x3 window handshake into one bundle.
// Signals:
//   i_data/i_valid/i_ready          incoming raster pixels
//   lb_data/lb_shift                line-buffer shift port
//   counter_col/counter_row         centre of the window presented downstream
//   win_valid/win_ready             window handshake
// Modports: slave = controller side, master = source/sink side.
interface line_window_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] lb_data;
  logic                  lb_shift;
  logic [31:0]           counter_col;
  logic [31:0]           counter_row;
  logic                  win_valid;
  logic                  win_ready;

  modport slave (
    input  i_data, i_valid, win_ready,
    output i_ready, lb_data, lb_shift, counter_col, counter_row, win_valid
  );

  modport master (
    output i_data, i_valid, win_ready,
    input  i_ready, lb_data, lb_shift, counter_col, counter_row, win_valid
  );
endinterface

// File: rtl/line_window_ctrl.sv
// rtl/line_window_ctrl.sv - frame sequencer feeding a 3x3 line buffer and issuing window handshakes
//
// Purpose: steps a WIDTH x WIDTH frame through FILL (prime the line buffer),
// RUN (one window per accepted pixel) and FLUSH (zero shifts that drain the
// last WIDTH+1 windows), then pulses frame_done for one cycle.
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous active-low reset
//   start       one-cycle frame request, honoured only in IDLE
//   bus         line_window_ctrl_if.slave (pixels, line-buffer shift, windows)
//   busy        high in every state except IDLE
//   frame_done  one-cycle pulse after the last window is consumed
//   stall_cnt   (LINE_WINDOW_CTRL_STALL_CNT_EN only) saturating count of
//               cycles with win_valid=1 and win_ready=0, cleared on start
// Optional feature macro: LINE_WINDOW_CTRL_STALL_CNT_EN
module line_window_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  line_window_ctrl_if.slave       bus,
  output logic                    busy,
  output logic                    frame_done
`ifdef LINE_WINDOW_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);

  localparam int CNT_W = $clog2(WIDTH * WIDTH + 1);
  // Count values compared before increment, so each names the last shift of its phase.
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(WIDTH * WIDTH - WIDTH - 2);
  localparam logic [CNT_W-1:0] FLUSH_N   = CNT_W'(WIDTH + 1);
  localparam logic [31:0]      EDGE_LAST = 32'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             win_valid_q, win_valid_d;
  logic [31:0]      col_q, col_d;
  logic [31:0]      row_q, row_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef LINE_WINDOW_CTRL_STALL_CNT_EN
  logic [31:0]      stall_q, stall_d;
`endif

  logic shift_ok;
  logic accept_phase;
  logic in_shift;
  logic flush_shift;
  logic win_shift;
  logic consume;

  always_comb begin
    shift_ok     = !win_valid_q || bus.win_ready;
    accept_phase = (state_q == S_FILL) || (state_q == S_RUN);
    in_shift     = accept_phase && shift_ok && bus.i_valid;
    // Flush shifts stop once all WIDTH+1 are issued; the FSM then waits for the last window.
    flush_shift  = (state_q == S_FLUSH) && (cnt_q != FLUSH_N) && shift_ok;
    win_shift    = ((state_q == S_RUN) && in_shift) || flush_shift;
    consume      = win_valid_q && bus.win_ready;
  end

  assign bus.i_ready     = accept_phase && shift_ok;
  assign bus.lb_data     = accept_phase ? bus.i_data : {DATA_WIDTH{1'b0}};
  assign bus.lb_shift    = in_shift || flush_shift;
  assign bus.win_valid   = win_valid_q;
  assign bus.counter_col = col_q;
  assign bus.counter_row = row_q;
  assign busy            = busy_q;
  assign frame_done      = done_q;
`ifdef LINE_WINDOW_CTRL_STALL_CNT_EN
  assign stall_cnt       = stall_q;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_valid_d = win_valid_q;
    col_d       = col_q;
    row_d       = row_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FILL;
          cnt_d   = '0;
        end
      end
      S_FILL: begin
        if (in_shift) begin
          if (cnt_q == FILL_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (in_shift) begin
          if (cnt_q == RUN_LAST) begin
            state_d = S_FLUSH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (flush_shift) begin
          cnt_d = cnt_q + 1'b1;
        end
        if ((cnt_q == FLUSH_N) && consume) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new window overrides the clear, giving one window per cycle back-to-back.
    if (win_shift) begin
      win_valid_d = 1'b1;
    end else if (consume) begin
      win_valid_d = 1'b0;
    end

    if (consume) begin
      if (col_q == EDGE_LAST) begin
        col_d = '0;
        row_d = (row_q == EDGE_LAST) ? 32'd0 : row_q + 32'd1;
      end else begin
        col_d = col_q + 32'd1;
      end
    end
  end

  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

`ifdef LINE_WINDOW_CTRL_STALL_CNT_EN
  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_IDLE) && start) begin
      stall_d = '0;
    end else if (win_valid_q && !bus.win_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      win_valid_q <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef LINE_WINDOW_CTRL_STALL_CNT_EN
      stall_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_valid_q <= win_valid_d;
      col_q       <= col_d;
      row_q       <= row_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef LINE_WINDOW_CTRL_STALL_CNT_EN
      stall_q     <= stall_d;
`endif
    end
  end

endmodule

// File: tb/tb_line_window_ctrl.sv
// tb/tb_line_window_ctrl.sv - self-checking bench for line_window_ctrl (WIDTH=5)
module tb_line_window_ctrl;
  localparam int W     = 5;
  localparam int NPIX  = W * W;
  localparam int FILLN = W + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic frame_done;
`ifdef LINE_WINDOW_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  line_window_ctrl_if #(.DATA_WIDTH(32)) bus ();

  line_window_ctrl #(.DATA_WIDTH(32), .WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef LINE_WINDOW_CTRL_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: frame progress as counts of line-buffer shifts and consumed windows.
  int shifts, cons, m_stall;
  bit m_busy, m_done_now;
  int cyc = 0;
  int obs_win, first_acc, first_wv, hold;
  logic [31:0] px [NPIX];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    shifts = 0; cons = 0; m_stall = 0; m_busy = 1'b0; m_done_now = 1'b0;
  endtask

  // A window exists once more than WIDTH+1 shifts happened than windows were consumed.
  function automatic bit exp_wv();
    return m_busy && !m_done_now && (shifts > FILLN + cons);
  endfunction

  function automatic bit accepting();
    return m_busy && !m_done_now && (shifts < NPIX);
  endfunction

  task automatic new_pixels();
    foreach (px[i]) px[i] = $urandom;
  endtask

  task automatic drive(input int vpct, input int rpct, input bit hold23, input bit rstart);
    bus.i_valid = ($urandom_range(0, 99) < vpct);
    bus.i_data  = accepting() ? px[shifts] : $urandom;
    if (hold23 && exp_wv() && cons == 2 * W + 3 && hold < 4) begin
      bus.win_ready = 1'b0;
      hold++;
    end else begin
      bus.win_ready = ($urandom_range(0, 99) < rpct);
    end
    start = (m_busy && rstart) ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  // Inputs are already driven; sample mid-cycle, check, advance model, step one edge.
  task automatic cycle();
    bit wv, ok, acc, fl, exp_shift;
    logic [31:0] exp_data;
    #3;
    wv  = exp_wv();
    ok  = !wv || bus.win_ready;
    acc = accepting();
    fl  = m_busy && !m_done_now && shifts >= NPIX && shifts < NPIX + FILLN;
    exp_shift = acc ? (bus.i_valid && ok) : (fl ? ok : 1'b0);
    exp_data  = acc ? px[shifts] : 32'd0;
    check("busy", 64'(busy), 64'(m_busy));
    check("frame_done", 64'(frame_done), 64'(m_done_now));
    check("win_valid", 64'(bus.win_valid), 64'(wv));
    check("i_ready", 64'(bus.i_ready), 64'(acc && ok));
    check("lb_shift", 64'(bus.lb_shift), 64'(exp_shift));
    check("lb_data", 64'(bus.lb_data), 64'(exp_data));
    check("counter_row", 64'(bus.counter_row), 64'((cons % NPIX) / W));
    check("counter_col", 64'(bus.counter_col), 64'(cons % W));
`ifdef LINE_WINDOW_CTRL_STALL_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
    if (bus.i_valid && bus.i_ready && first_acc < 0) first_acc = cyc;
    if (bus.win_valid && first_wv < 0) first_wv = cyc;
    if (bus.win_valid && bus.win_ready) obs_win++;
    if (wv && !bus.win_ready) m_stall++;
    if (exp_shift) shifts++;
    if (m_done_now) begin
      m_busy = 1'b0; m_done_now = 1'b0;
    end else if (wv && bus.win_ready) begin
      cons++;
      if (cons == NPIX) m_done_now = 1'b1;
    end else if (!m_busy && start) begin
      m_busy = 1'b1; shifts = 0; cons = 0; m_stall = 0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame();
    new_pixels();
    first_acc = -1; first_wv = -1; obs_win = 0; hold = 0;
    start = 1'b1; bus.i_valid = 1'b0; bus.win_ready = 1'b1; bus.i_data = $urandom;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_frame(input int vpct, input int rpct, input bit hold23, input bit rstart);
    int n;
    bit held_checked;
    held_checked = 1'b0;
    begin_frame();
    n = 0;
    while (m_busy && n < 600) begin
      drive(vpct, rpct, hold23, rstart);
      cycle();
      n++;
      if (hold23 && hold == 4 && !held_checked) begin
        held_checked = 1'b1;
        check("hold_row", 64'(bus.counter_row), 64'd2);
        check("hold_col", 64'(bus.counter_col), 64'd3);
        check("hold_win_valid", 64'(bus.win_valid), 64'd1);
        check("hold_i_ready", 64'(bus.i_ready), 64'd0);
        check("hold_lb_shift", 64'(bus.lb_shift), 64'd0);
`ifdef LINE_WINDOW_CTRL_STALL_CNT_EN
        check("hold_stall_cnt", 64'(stall_cnt), 64'd4);
`endif
      end
    end
    start = 1'b0;
    check("frame_ended_busy", 64'(busy), 64'd0);
    check("window_count", 64'(obs_win), 64'(NPIX));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    check({tag, "_win_valid"}, 64'(bus.win_valid), 64'd0);
    check({tag, "_i_ready"}, 64'(bus.i_ready), 64'd0);
    check({tag, "_lb_shift"}, 64'(bus.lb_shift), 64'd0);
    check({tag, "_lb_data"}, 64'(bus.lb_data), 64'd0);
    check({tag, "_row"}, 64'(bus.counter_row), 64'd0);
    check({tag, "_col"}, 64'(bus.counter_col), 64'd0);
`ifdef LINE_WINDOW_CTRL_STALL_CNT_EN
    check({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
`endif
  endtask

  initial begin
    int n;
    model_reset();
    first_acc = -1; first_wv = -1; obs_win = 0; hold = 0;
    bus.i_valid = 1'b1; bus.i_data = 32'hDEAD_BEEF; bus.win_ready = 1'b1;
    foreach (px[i]) px[i] = 32'd0;
    #2;
    check_reset_values("por");
    @(posedge clk); #1;
    cycle();
    rst = 1'b1;
    // Idle with valid pixels offered: nothing is accepted.
    for (int i = 0; i < 3; i++) begin
      bus.i_valid = 1'b1; bus.i_data = $urandom;
      cycle();
    end

    // Continuous stream, always-ready sink.
    run_frame(100, 100, 1'b0, 1'b0);
    check("first_window_latency", 64'(first_wv - first_acc), 64'd7);

    // Sink stalls four cycles on window (2,3).
    run_frame(100, 100, 1'b1, 1'b0);

    // Input gaps during RUN.
    run_frame(50, 100, 1'b0, 1'b0);

    // Random gaps and back-pressure, start pulses while busy and in DONE.
    run_frame(70, 60, 1'b0, 1'b1);
    run_frame(80, 80, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) begin
      bus.i_valid = 1'b1; bus.win_ready = $urandom_range(0, 1);
      cycle();
    end

    // Abort at window (1,2) with an asynchronous reset.
    begin_frame();
    n = 0;
    while (!(exp_wv() && cons == W + 2) && n < 200) begin
      drive(100, 100, 1'b0, 1'b0);
      cycle();
      n++;
    end
    check("abort_row", 64'(bus.counter_row), 64'd1);
    check("abort_col", 64'(bus.counter_col), 64'd2);
    bus.i_valid = 1'b1;
    rst = 1'b0;
    #1;
    check_reset_values("abort");
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) cycle();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.i_valid = 1'b1; bus.i_data = $urandom;
      cycle();
    end
    run_frame(100, 100, 1'b0, 1'b0);
    check("post_abort_latency", 64'(first_wv - first_acc), 64'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
